ddr2_host_cmd_arbiter: RTL
==========================

# ddr2_host_cmd_arbiter

Round-robin arbiter that shares the DDR2 controller's single host command FIFO write port between `NREQ` independent requesters. Each requester presents packed command words with a valid/ready handshake and may lock the grant for a multi-word burst via `req_last`. The arbiter throttles on the controller's public `FILLCOUNT`/`NOTFULL` contract: no new grant above the high-water mark, no FIFO write while `NOTFULL` is low. It sits between the host-side clients and the DDR2 front end, alongside the FIFO flow-control monitor.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `DW`, 32: command word width.
- `HIGH_WATER`, 33: `fillcount` level at or above which no new grant is issued.
- `STALL_W`, 16: stall counter width.

- `clk`  in  1  sole clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester word valid.
- `req_data`  in  NREQ*DW  per-requester word; requester i occupies bits [i*DW +: DW].
- `req_last`  in  NREQ  marks the final word of the requester's burst.
- `req_ready`  out  NREQ  word accepted when valid & ready.
- `fillcount`  in  7  controller FIFO fill level.
- `notfull`  in  1  controller FIFO can accept a write this cycle.
- `fifo_we`  out  1  write strobe to the controller FIFO.
- `fifo_data`  out  DW  write data to the controller FIFO.
- `busy`  out  1  grant held (state GRANT).
- `gnt_id`  out  3  index of the current or last granted requester.
- `stall_clr`  in  1  synchronous clear of `stall_count`.
- `stall_count`  out  STALL_W  saturating stall-cycle count.

## Operation
- FSM has two states. Both transitions take effect at the clock edge.
  - IDLE → GRANT when any `req_valid` is high and `fillcount < HIGH_WATER`.
    - Winner: first requester with valid set, searching round-robin from `ptr+1` (mod NREQ).
    - On the transition, `gnt_id` and `ptr` both load the winner's index.
  - GRANT → IDLE on the cycle an accepted word has `req_last[gnt_id]` = 1.
  - Otherwise the FSM stays in GRANT; the burst is locked.
- The following three signals are combinational from registered state and current inputs:
  - `req_ready[i]` = (state==GRANT) & (i==gnt_id) & `notfull`.
  - `fifo_we` = `req_valid[gnt_id]` & `req_ready[gnt_id]`.
  - `fifo_data` = `req_data[gnt_id]`; its value is don't-care when `fifo_we`=0.
- `fillcount` gates only new grants. An in-progress burst continues past `HIGH_WATER` while `notfull`=1.
- A requester dropping `req_valid` mid-burst keeps the grant. There is no timeout.
- `stall_count` increments, saturating at all-ones, in either of these cycles:
  - GRANT & `req_valid[gnt_id]` & !`notfull`;
  - IDLE & |`req_valid` & `fillcount >= HIGH_WATER`.
- `stall_clr` has priority over increment.
- Reset values: state IDLE, `ptr` = NREQ-1 (so requester 0 wins first), `gnt_id` 0, `stall_count` 0. Consequently `req_ready` 0, `fifo_we` 0, `busy` 0.

## Timing
- Latency from `req_valid` rising in IDLE to `req_ready`: 1 cycle, provided `notfull`=1.
- Throughput within a burst: 1 word/cycle while `notfull`=1.
- At least one IDLE bubble cycle separates consecutive bursts, including same-requester bursts.
- Single-word request (`req_last`=1 on the first word): GRANT lasts one cycle if `notfull`=1.
- A `notfull` deassertion takes effect on `req_ready` in the same cycle. No word is written while `notfull`=0.
- `fillcount` equal to `HIGH_WATER` blocks a grant; `HIGH_WATER`-1 permits it.
- `reset_n` low mid-burst: the FSM immediately goes to IDLE and `req_ready`/`fifo_we` drop asynchronously. The partially written burst is the requester's responsibility.
- Comparison width: `fillcount` is 7 bits unsigned. `HIGH_WATER` is compared as 7 bits.

## Test plan
- Reset, then all requesters assert valid with `req_last`=1 and `notfull`=1 held. Required grant order: 0,1,2,3,0. Each grant is one-cycle GRANT plus one IDLE cycle, giving one `fifo_we` every 2 cycles.
- Requester 2 sends a 4-word burst A0..A3 (last on A3) while requester 1 is valid. Required `fifo_data` sequence: A0,A1,A2,A3 on 4 consecutive cycles, then requester 1 is granted after the bubble.
- `fillcount`=33 with requester 0 valid: no grant, `stall_count` counts 1 per cycle. Dropping `fillcount` to 32 gives a grant on the next edge.
- `notfull`=0 for 3 cycles in the middle of a burst: `req_ready`=0 and `fifo_we`=0 for those 3 cycles, `stall_count` +3, no word lost or duplicated.
- Pulse `reset_n` low mid-burst: outputs drop immediately, `stall_count` returns to 0. After release, requester 0 wins first.
- Hold the stall condition 2^16+5 cycles: `stall_count` saturates at 0xFFFF. `stall_clr` then gives 0 on the next edge.

Source files
------------

// File: rtl/ddr2_host_cmd_arbiter.sv
// Round-robin arbiter sharing the DDR2 host command FIFO write port between NREQ
// requesters, with burst locking, fill-level throttling and a saturating stall counter.
module ddr2_host_cmd_arbiter #(
  parameter int NREQ       = 4,
  parameter int DW         = 32,
  parameter int HIGH_WATER = 33,
  parameter int STALL_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  input  logic [6:0]           fillcount,
  input  logic                 notfull,
  output logic                 fifo_we,
  output logic [DW-1:0]        fifo_data,
  output logic                 busy,
  output logic [2:0]           gnt_id,
  input  logic                 stall_clr,
  output logic [STALL_W-1:0]   stall_count
);

  localparam logic [6:0] HW       = 7'(HIGH_WATER);
  localparam logic [2:0] LAST_IDX = 3'(NREQ - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [2:0]         gnt_q, gnt_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  logic               sel_valid, sel_last;
  logic [DW-1:0]      sel_data;
  logic               win_found;
  logic [2:0]         win_idx;
  logic               any_valid, below_hw, stall_inc;

  // Mux out the granted requester's lane without indexing by a wider id.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (3'(i) == gnt_q) begin
        sel_valid    = req_valid[i];
        sel_last     = req_last[i];
        sel_data     = req_data[i*DW +: DW];
        req_ready[i] = (state_q == GRANT) & notfull;
      end
    end
  end

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!win_found && (j == (int'(ptr_q) + k) % NREQ) && req_valid[j]) begin
          win_found = 1'b1;
          win_idx   = 3'(j);
        end
      end
    end
  end

  assign any_valid = |req_valid;
  assign below_hw  = fillcount < HW;
  assign fifo_we   = sel_valid & (state_q == GRANT) & notfull;
  assign fifo_data = sel_data;
  assign busy      = (state_q == GRANT);
  assign gnt_id    = gnt_q;
  assign stall_count = stall_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (any_valid && below_hw && win_found) begin
          state_d = GRANT;
          ptr_d   = win_idx;
          gnt_d   = win_idx;
        end
      end
      GRANT: begin
        if (fifo_we && sel_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stalls: granted word blocked by a full FIFO, or pending requests held off by high water.
  always_comb begin
    stall_inc = ((state_q == GRANT) & sel_valid & ~notfull) |
                ((state_q == IDLE) & any_valid & ~below_hw);
    if (stall_clr)                       stall_d = '0;
    else if (stall_inc && (stall_q != '1)) stall_d = stall_q + 1'b1;
    else                                 stall_d = stall_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= LAST_IDX;
      gnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      stall_q <= stall_d;
    end
  end

endmodule
